dmem_dma: RTL and testbench

Word-granular copy/fill engine that acts as a bus initiator on the data-memory port: it drives address, write data and write-enable into the data memory, and consumes its combinational read data. It sits beside the processor core. A top-level mux hands the data-memory port to this block whenever BUSY is high, so a program can block-copy or clear memory, or stream words to the memory-mapped HEX/LEDR/LEDG registers, without executing a load/store loop.

---
 rtl/dmem_dma_pkg.sv | 31 +++
 rtl/dmem_dma_if.sv | 35 +++
 rtl/dmem_dma.sv | 165 ++++++++++++++++
 tb/tb_dmem_dma.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_dma_pkg.sv
// dmem_dma shared definitions.
// State encoding, mode constants and I/O map.
package dmem_dma_pkg;

  localparam int DBITS    = 32;
  localparam int WORDBITS = 2;
  localparam int LENBITS  = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FIN
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam logic [DBITS-1:0] HEX_ADDR  = 32'hFFFF_0000;
  localparam logic [DBITS-1:0] LEDR_ADDR = 32'hFFFF_0020;
  localparam logic [DBITS-1:0] LEDG_ADDR = 32'hFFFF_0040;
  localparam logic [DBITS-1:0] KEY_ADDR  = 32'hFFFF_0100;
  localparam logic [DBITS-1:0] SW_ADDR   = 32'hFFFF_0120;

  function automatic logic misaligned(
    input logic [DBITS-1:0] a
  );
    return |a[WORDBITS-1:0];
  endfunction

endpackage

// File: rtl/dmem_dma_if.sv
// dmem_dma command and data-memory bus.
// master = engine side, slave = host/memory side.
interface dmem_dma_if;
  import dmem_dma_pkg::*;

  logic               START;
  logic               MODE;
  logic [DBITS-1:0]   SRCADDR;
  logic [DBITS-1:0]   DSTADDR;
  logic [LENBITS-1:0] LEN;
  logic [DBITS-1:0]   FILLVAL;
  logic               ABORT;
  logic [DBITS-1:0]   ADDROUT;
  logic [DBITS-1:0]   DOUT;
  logic               WE;
  logic [DBITS-1:0]   DIN;
  logic               BUSY;
  logic               DONE;
  logic               ERR;

  modport master (
    input  START, MODE, SRCADDR, DSTADDR,
    input  LEN, FILLVAL, ABORT, DIN,
    output ADDROUT, DOUT, WE,
    output BUSY, DONE, ERR
  );

  modport slave (
    output START, MODE, SRCADDR, DSTADDR,
    output LEN, FILLVAL, ABORT, DIN,
    input  ADDROUT, DOUT, WE,
    input  BUSY, DONE, ERR
  );

endinterface

// File: rtl/dmem_dma.sv
// dmem_dma: word copy/fill engine on the
// data-memory port; all outputs registered.
module dmem_dma
  import dmem_dma_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  dmem_dma_if.master   bus
);

  localparam logic [DBITS-1:0] STRIDE =
    DBITS'(1 << WORDBITS);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [DBITS-1:0]   src_q, src_d;
  logic [DBITS-1:0]   dst_q, dst_d;
  logic [LENBITS-1:0] cnt_q, cnt_d;
  logic [DBITS-1:0]   pat_q, pat_d;
  logic [DBITS-1:0]   rbuf_q, rbuf_d;
  logic [DBITS-1:0]   addr_q, addr_d;
  logic [DBITS-1:0]   dout_q, dout_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               bad_addr;

  // Command decode, next state, and the
  // output values for the next state.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    rbuf_d  = rbuf_q;
    err_d   = err_q;
    bad_addr = misaligned(bus.DSTADDR) ||
      (bus.MODE == MODE_COPY &&
       misaligned(bus.SRCADDR));

    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          mode_d = bus.MODE;
          src_d  = bus.SRCADDR;
          dst_d  = bus.DSTADDR;
          cnt_d  = bus.LEN;
          pat_d  = bus.FILLVAL;
          err_d  = 1'b0;
          if (bad_addr) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (bus.LEN == '0) begin
            state_d = S_FIN;
          end else if (bus.MODE == MODE_FILL) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        rbuf_d  = bus.DIN;
        src_d   = src_q + STRIDE;
        state_d = S_WRITE;
        if (bus.ABORT) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_WRITE: begin
        dst_d = dst_q + STRIDE;
        cnt_d = cnt_q - LENBITS'(1);
        if (cnt_q == LENBITS'(1)) begin
          state_d = S_FIN;
        end else if (mode_q == MODE_FILL) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
        if (bus.ABORT) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    addr_d = '0;
    dout_d = '0;
    we_d   = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      S_READ: begin
        addr_d = src_d;
        busy_d = 1'b1;
      end
      S_WRITE: begin
        addr_d = dst_d;
        dout_d = (mode_d == MODE_FILL) ?
          pat_d : rbuf_d;
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_FIN: begin
        done_d = 1'b1;
      end
      default: begin
        addr_d = '0;
      end
    endcase
  end

  // State, working registers and registered
  // outputs; synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      rbuf_q  <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      rbuf_q  <= rbuf_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.ADDROUT = addr_q;
  assign bus.DOUT    = dout_q;
  assign bus.WE      = we_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_dmem_dma.sv
// Bench for dmem_dma: scoreboard of expected
// writes and DONE pulses, checked by a monitor.
module tb_dmem_dma;
  import dmem_dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_dma_if dif();

  dmem_dma dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (dif)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:255];
  logic [31:0] hex_q;
  logic        pl_we = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  assign dif.DIN = mem[dif.ADDROUT[9:2]];

  always @(posedge clk) begin
    if (dif.WE) begin
      mem[dif.ADDROUT[9:2]] <= dif.DOUT;
    end else if (pl_we) begin
      mem[pl_idx] <= pl_data;
    end
  end

  always @(posedge clk) begin
    if (rst) hex_q <= '0;
    else if (dif.WE && dif.ADDROUT == HEX_ADDR)
      hex_q <= dif.DOUT;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int   c;
    logic e;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h",
               name, act, exp);
    end
  endtask

  // Monitor: pop expectations on WE / DONE.
  always @(negedge clk) begin
    if (dif.WE) begin
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_write got=%h/%h want=none",
                 dif.ADDROUT, dif.DOUT);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", dif.ADDROUT, w.a);
        chk("wr_data", dif.DOUT, w.d);
      end
    end
    if (dif.DONE) begin
      if (dq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_done got=cyc%0d want=none",
                 cyc);
      end else begin
        dn_t n;
        n = dq.pop_front();
        chk("done_cyc", 32'(cyc), 32'(n.c));
        chk("done_err", {31'd0, dif.ERR},
            {31'd0, n.e});
      end
    end
  end

  task automatic pl(
    input logic [7:0]  idx,
    input logic [31:0] d
  );
    pl_we   = 1'b1;
    pl_idx  = idx;
    pl_data = d;
    @(posedge clk);
    #1;
    pl_we = 1'b0;
  endtask

  task automatic start_op(
    input  logic        m,
    input  logic [31:0] s,
    input  logic [31:0] d,
    input  logic [11:0] n,
    input  logic [31:0] f,
    output int          k
  );
    @(posedge clk);
    #1;
    dif.MODE    = m;
    dif.SRCADDR = s;
    dif.DSTADDR = d;
    dif.LEN     = n;
    dif.FILLVAL = f;
    dif.START   = 1'b1;
    k = cyc + 1;
    @(posedge clk);
    #1;
    dif.START = 1'b0;
  endtask

  task automatic push_wr(
    input logic [31:0] a,
    input logic [31:0] d
  );
    wr_t w;
    w.a = a;
    w.d = d;
    wq.push_back(w);
  endtask

  task automatic push_dn(input int c, input logic e);
    dn_t n;
    n.c = c;
    n.e = e;
    dq.push_back(n);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && dq.size() != 0; i++)
      @(posedge clk);
    if (dq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=pending want=done",
               name);
      dq.delete();
    end
    @(posedge clk);
    #1;
    chk({name, "_wq_empty"}, 32'(wq.size()), 32'd0);
    wq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    dif.START   = 1'b0;
    dif.MODE    = 1'b0;
    dif.SRCADDR = '0;
    dif.DSTADDR = '0;
    dif.LEN     = '0;
    dif.FILLVAL = '0;
    dif.ABORT   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      pl(8'(i), 32'(i) ^ 32'h5500_0000);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, dif.BUSY}, 32'd0);
    chk("rst_done", {31'd0, dif.DONE}, 32'd0);
    chk("rst_err",  {31'd0, dif.ERR},  32'd0);
    chk("rst_we",   {31'd0, dif.WE},   32'd0);
    chk("rst_addr", dif.ADDROUT, 32'd0);
    chk("rst_dout", dif.DOUT, 32'd0);
    rst = 1'b0;

    // Fill 4 words at 0x40.
    start_op(1'b1, 32'h0, 32'h40, 12'd4,
             32'hA5A5A5A5, k);
    for (int i = 0; i < 4; i++)
      push_wr(32'h40 + 32'(4 * i), 32'hA5A5A5A5);
    push_dn(k + 4, 1'b0);
    chk("fill_busy", {31'd0, dif.BUSY}, 32'd1);
    wait_done("fill");
    chk("fill_mem", mem[19], 32'hA5A5A5A5);

    // Copy 3 words 0x0 -> 0x100.
    pl(8'd0, 32'd1);
    pl(8'd1, 32'd2);
    pl(8'd2, 32'd3);
    start_op(1'b0, 32'h0, 32'h100, 12'd3, 32'h0, k);
    push_wr(32'h100, 32'd1);
    push_wr(32'h104, 32'd2);
    push_wr(32'h108, 32'd3);
    push_dn(k + 6, 1'b0);
    chk("copy_rd_we", {31'd0, dif.WE}, 32'd0);
    chk("copy_busy", {31'd0, dif.BUSY}, 32'd1);
    wait_done("copy");
    chk("copy_m0", mem[64], 32'd1);
    chk("copy_m1", mem[65], 32'd2);
    chk("copy_m2", mem[66], 32'd3);

    // Misaligned destination.
    start_op(1'b1, 32'h0, 32'h102, 12'd4,
             32'h99, k);
    push_dn(k, 1'b1);
    chk("mis_busy", {31'd0, dif.BUSY}, 32'd0);
    wait_done("mis_dst");

    // Misaligned source in copy mode.
    start_op(1'b0, 32'h1, 32'h100, 12'd2, 32'h0, k);
    push_dn(k, 1'b1);
    wait_done("mis_src");

    // Source alignment ignored in fill mode.
    start_op(1'b1, 32'h3, 32'h200, 12'd1,
             32'hCAFE, k);
    push_wr(32'h200, 32'hCAFE);
    push_dn(k + 1, 1'b0);
    wait_done("fill_src_ign");

    // Zero length.
    start_op(1'b1, 32'h0, 32'h40, 12'd0, 32'h1, k);
    push_dn(k, 1'b0);
    wait_done("len0");

    // Abort during third write of a 10-word fill.
    start_op(1'b1, 32'h0, 32'h80, 12'd10,
             32'h5A, k);
    push_wr(32'h80, 32'h5A);
    push_wr(32'h84, 32'h5A);
    push_wr(32'h88, 32'h5A);
    push_dn(k + 3, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    dif.ABORT = 1'b1;
    @(posedge clk);
    #1;
    dif.ABORT = 1'b0;
    wait_done("abort");

    // Address wrap.
    start_op(1'b1, 32'h0, 32'hFFFFFFFC, 12'd2,
             32'h77, k);
    push_wr(32'hFFFFFFFC, 32'h77);
    push_wr(32'h0, 32'h77);
    push_dn(k + 2, 1'b0);
    wait_done("wrap");

    // HEX register write.
    start_op(1'b1, 32'h0, HEX_ADDR, 12'd1,
             32'h1234, k);
    push_wr(HEX_ADDR, 32'h1234);
    push_dn(k + 1, 1'b0);
    wait_done("hex");
    chk("hex_val", hex_q, 32'h1234);

    // Overlapping copy with a stray START.
    pl(8'd0, 32'd7);
    pl(8'd1, 32'd11);
    pl(8'd2, 32'd12);
    pl(8'd3, 32'd13);
    start_op(1'b0, 32'h0, 32'h4, 12'd3, 32'h0, k);
    push_wr(32'h4, 32'd7);
    push_wr(32'h8, 32'd7);
    push_wr(32'hC, 32'd7);
    push_dn(k + 6, 1'b0);
    @(posedge clk);
    #1;
    dif.MODE    = 1'b1;
    dif.DSTADDR = 32'h200;
    dif.LEN     = 12'd1;
    dif.FILLVAL = 32'hBAD;
    dif.START   = 1'b1;
    @(posedge clk);
    #1;
    dif.START = 1'b0;
    wait_done("overlap");
    chk("ovl_m1", mem[1], 32'd7);
    chk("ovl_m2", mem[2], 32'd7);
    chk("ovl_m3", mem[3], 32'd7);

    // Reset mid-copy: one write, then nothing.
    start_op(1'b0, 32'h0, 32'h100, 12'd3, 32'h0, k);
    push_wr(32'h100, 32'd7);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid_busy", {31'd0, dif.BUSY}, 32'd0);
    chk("rmid_we",   {31'd0, dif.WE},   32'd0);
    chk("rmid_done", {31'd0, dif.DONE}, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rmid_wq", 32'(wq.size()), 32'd0);
    chk("rmid_m1", mem[65], 32'd2);
    chk("rmid_m0", mem[64], 32'd7);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
